// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU result words and their status flags, with a valid/ready drain
// and sticky carry/overflow summary bits accumulated over accepted pushes.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           z_in,
  input  logic                       sign_in,
  input  logic                       zero_in,
  input  logic                       carry_in,
  input  logic                       parity_in,
  input  logic                       overflow_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           z_out,
  output logic                       sign_out,
  output logic                       zero_out,
  output logic                       carry_out,
  output logic                       parity_out,
  output logic                       overflow_out,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       sticky_clr,
  output logic                       sticky_carry,
  output logic                       sticky_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 5;

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          sticky_carry_r;
  logic          sticky_overflow_r;

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [EW-1:0] head_s;

  // Handshake status comes from registered state only, never from out_ready.
  always_comb begin
    full_s  = (count_r == CW'(DEPTH));
    empty_s = (count_r == {CW{1'b0}});
    push_s  = in_valid & ~full_s;
    pop_s   = out_ready & ~empty_s;
  end

  // Entry storage; contents are never reset because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {sign_in, zero_in, carry_in, parity_in, overflow_in, z_in};
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky summary bits: a setting push in the same cycle overrides a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry_r    <= 1'b0;
      sticky_overflow_r <= 1'b0;
    end else begin
      sticky_carry_r    <= (sticky_carry_r & ~sticky_clr) | (push_s & carry_in);
      sticky_overflow_r <= (sticky_overflow_r & ~sticky_clr) | (push_s & overflow_in);
    end
  end

  // Head entry presented directly from storage, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      head_s = {EW{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign in_ready        = ~full_s;
  assign out_valid       = ~empty_s;
  assign count           = count_r;
  assign sticky_carry    = sticky_carry_r;
  assign sticky_overflow = sticky_overflow_r;
  assign z_out           = head_s[WIDTH-1:0];
  assign overflow_out    = head_s[WIDTH];
  assign parity_out      = head_s[WIDTH+1];
  assign carry_out       = head_s[WIDTH+2];
  assign zero_out        = head_s[WIDTH+3];
  assign sign_out        = head_s[WIDTH+4];

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: a queue model predicts head, count,
// handshake and sticky bits every cycle.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] z_in;
  logic             sign_in, zero_in, carry_in, parity_in, overflow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z_out;
  logic             sign_out, zero_out, carry_out, parity_out, overflow_out;
  logic [2:0]       count;
  logic             sticky_clr;
  logic             sticky_carry;
  logic             sticky_overflow;

  int total = 0;
  int bad   = 0;
  logic [20:0] sbq [$];
  logic        m_sc;
  logic        m_so;

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .z_in(z_in),
    .sign_in(sign_in), .zero_in(zero_in), .carry_in(carry_in),
    .parity_in(parity_in), .overflow_in(overflow_in),
    .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out),
    .sign_out(sign_out), .zero_out(zero_out), .carry_out(carry_out),
    .parity_out(parity_out), .overflow_out(overflow_out),
    .count(count), .sticky_clr(sticky_clr),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Head, handshake flags and flag outputs against the model's queue front.
  task automatic check_head();
    logic [20:0] e;
    e = (sbq.size() > 0) ? sbq[0] : 21'h0;
    check_val("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    check_val("in_ready", 32'(in_ready), 32'(sbq.size() != DEPTH));
    check_val("z_out", 32'(z_out), 32'(e[15:0]));
    check_val("flags_out", 32'({sign_out, zero_out, carry_out, parity_out, overflow_out}),
              32'(e[20:16]));
  endtask

  task automatic check_state();
    check_val("count", 32'(count), 32'(sbq.size()));
    check_val("sticky_carry", 32'(sticky_carry), 32'(m_sc));
    check_val("sticky_overflow", 32'(sticky_overflow), 32'(m_so));
  endtask

  // One clock: f = {sign, zero, carry, parity, overflow}.
  task automatic step(input logic iv, input logic [15:0] z, input logic [4:0] f,
                      input logic ordy, input logic clr);
    logic pa, po;
    in_valid = iv; z_in = z;
    {sign_in, zero_in, carry_in, parity_in, overflow_in} = f;
    out_ready = ordy; sticky_clr = clr;
    #1;
    check_head();
    pa = iv && (sbq.size() < DEPTH);
    po = ordy && (sbq.size() > 0);
    @(posedge clk); #1;
    if (po) void'(sbq.pop_front());
    if (pa) sbq.push_back({f, z});
    m_sc = (m_sc & ~clr) | (pa & f[2]);
    m_so = (m_so & ~clr) | (pa & f[0]);
    in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    sbq.delete(); m_sc = 1'b0; m_so = 1'b0;
    check_head();
    check_state();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    z_in = 16'h0; {sign_in, zero_in, carry_in, parity_in, overflow_in} = 5'h0;
    m_sc = 1'b0; m_so = 1'b0;

    // 1: asynchronous reset mid-clock
    @(posedge clk); #1;
    mid_reset();
    step(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);

    // 2: single push / pop of 0x8000+0x8000 result
    step(1'b1, 16'h0000, 5'b01111, 1'b0, 1'b0);
    step(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);

    // 3: fill to full, overflow push ignored, drain in order
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 5'(i), 1'b0, 1'b0);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h0006, 5'h0, 1'b1, 1'b0);
    drain();

    // 4: simultaneous push/pop at count=2, then across pointer wrap
    step(1'b1, 16'h00AA, 5'h0, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 5'h0, 1'b0, 1'b0);
    step(1'b1, 16'h00CC, 5'h0, 1'b1, 1'b0);
    check_val("pp_head", 32'(z_out), 32'h00BB);
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'($urandom), 5'($urandom), 1'b1, 1'b0);
    drain();

    // 5: sticky set, clear, and clear-with-set
    step(1'b1, 16'h1111, 5'b00100, 1'b0, 1'b0);
    step(1'b0, 16'h0, 5'h0, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 5'b00001, 1'b0, 1'b1);
    check_val("sticky_set_wins", 32'(sticky_overflow), 32'd1);
    drain();

    // 6: reset mid-operation, then fresh push
    step(1'b1, 16'h0A01, 5'b00100, 1'b0, 1'b0);
    step(1'b1, 16'h0A02, 5'b00000, 1'b0, 1'b0);
    step(1'b1, 16'h0A03, 5'b00010, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 16'h1234, 5'b10000, 1'b0, 1'b0);
    check_val("post_reset_head", 32'(z_out), 32'h1234);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
